// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_edge input-conditioning block.
package debounce_pkg;

  // Debounce FSM state encoding
  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// SYNC_STAGES-deep synchronizer for one asynchronous input.
// Reusable for any other raw asynchronous level.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw level through the chain; bit 0 is the metastable-prone stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounce + edge detect: synchronizes din, accepts a new level only after
// STABLE_CYCLES consecutive equal samples, emits one-cycle rise/fall pulses.
// Optional feature macro: DEBOUNCE_TOGGLE_EN adds a 'toggle' output that
// flips on every rise pulse.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, rise_n, fall_n, busy_n;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (sync)
  );

  // Next-state, stability counter and next registered outputs
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      S_LOW: begin
        if (sync) begin
          state_n = S_RISE_CHK;
          cnt_n   = CNT_ONE;
        end
      end
      S_RISE_CHK: begin
        if (!sync) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = S_HIGH;
          level_n = 1'b1;
          rise_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_n = S_FALL_CHK;
          cnt_n   = CNT_ONE;
        end
      end
      S_FALL_CHK: begin
        if (sync) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = S_LOW;
          level_n = 1'b0;
          fall_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
    busy_n = (state_n == S_RISE_CHK) || (state_n == S_FALL_CHK);
  end

  // State, counter and all outputs are registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
      fall  <= fall_n;
      busy  <= busy_n;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // On/off latch flipped by each accepted press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) toggle <= 1'b0;
    else       toggle <= toggle ^ rise_n;
  end
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: vector table for press/release and glitch,
// hand sequences for reset, bounce and reset during qualification.
module tb_debounce_edge;

  logic clk, reset, din;
  logic level, rise, fall, busy;
`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle;
`endif

  int total = 0;
  int bad   = 0;

  debounce_edge dut (
    .clk    (clk),
    .reset  (reset),
    .din    (din),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    .toggle (toggle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic din;
    logic lv;
    logic rs;
    logic fl;
    logic bs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic d, logic lv, logic rs, logic fl, logic bs);
    vec_t v;
    v.din = d; v.lv = lv; v.rs = rs; v.fl = fl; v.bs = bs;
    return v;
  endfunction

  // Hold din for n cycles, checking nothing (used to return to idle)
  task automatic idle(input logic d, input int n);
    din = d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int rise_cnt, fall_cnt, rise_at;

  initial begin
    din   = 1'b1;
    reset = 1'b1;

    // Reset with din high; release at 20 ns
    #12;
    chk("rst_level", level, 0);
    chk("rst_rise",  rise,  0);
    chk("rst_fall",  fall,  0);
    chk("rst_busy",  busy,  0);
    #8 reset = 1'b0;
    rise_cnt = 0; rise_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rise) begin rise_cnt++; if (rise_at < 0) rise_at = c; end
    end
    chk("rst_rise_edge", rise_at, 6);
    chk("rst_rise_cnt",  rise_cnt, 1);
    chk("rst_level_hi",  level, 1);
    idle(1'b0, 10);
    chk("idle_level", level, 0);

    // Clean press/release then 3-cycle glitch, one vector per cycle
    for (int i = 0; i < 10; i++) begin
      case (i + 1)
        1, 2:    tbl.push_back(mk(1, 0, 0, 0, 0));
        3, 4, 5: tbl.push_back(mk(1, 0, 0, 0, 1));
        6:       tbl.push_back(mk(1, 1, 1, 0, 0));
        default: tbl.push_back(mk(1, 1, 0, 0, 0));
      endcase
    end
    for (int i = 11; i <= 20; i++) begin
      case (i)
        11, 12:     tbl.push_back(mk(0, 1, 0, 0, 0));
        13, 14, 15: tbl.push_back(mk(0, 1, 0, 0, 1));
        16:         tbl.push_back(mk(0, 0, 0, 1, 0));
        default:    tbl.push_back(mk(0, 0, 0, 0, 0));
      endcase
    end
    for (int i = 1; i <= 9; i++) begin
      if (i <= 2)      tbl.push_back(mk(1, 0, 0, 0, 0));
      else if (i == 3) tbl.push_back(mk(1, 0, 0, 0, 1));
      else if (i <= 5) tbl.push_back(mk(0, 0, 0, 0, 1));
      else             tbl.push_back(mk(0, 0, 0, 0, 0));
    end

    foreach (tbl[i]) begin
      din = tbl[i].din;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_level", i), level, tbl[i].lv);
      chk($sformatf("vec%0d_rise",  i), rise,  tbl[i].rs);
      chk($sformatf("vec%0d_fall",  i), fall,  tbl[i].fl);
      chk($sformatf("vec%0d_busy",  i), busy,  tbl[i].bs);
    end

    // Bounce: toggle 8 cycles (1,0,...), then hold high
    rise_cnt = 0; fall_cnt = 0; rise_at = -1;
    for (int c = 1; c <= 20; c++) begin
      din = (c > 8) ? 1'b1 : ((c % 2) == 1);
      @(posedge clk); #1;
      if (rise) begin rise_cnt++; if (rise_at < 0) rise_at = c; end
      if (fall) fall_cnt++;
      if (c <= 10 && level) chk("bounce_level_low", level, 0);
    end
    chk("bounce_rise_edge", rise_at, 14);
    chk("bounce_rise_cnt",  rise_cnt, 1);
    chk("bounce_fall_cnt",  fall_cnt, 0);
    chk("bounce_level",     level, 1);
    idle(1'b0, 10);

    // Reset asynchronously while qualifying (cnt = 2 after edge 4)
    din = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    chk("midq_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midq_busy_rst",  busy,  0);
    chk("midq_level_rst", level, 0);
    rise_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (rise) rise_cnt++;
    end
    chk("midq_no_rise", rise_cnt, 0);
    @(negedge clk); reset = 1'b0;
    rise_cnt = 0; rise_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (rise) begin rise_cnt++; if (rise_at < 0) rise_at = c; end
    end
    chk("midq_rise_edge", rise_at, 6);
    chk("midq_rise_cnt",  rise_cnt, 1);
    idle(1'b0, 10);

`ifdef DEBOUNCE_TOGGLE_EN
    // Fresh reset, then three clean presses
    reset = 1'b1;
    #1;
    chk("tgl_rst", toggle, 0);
    @(negedge clk); reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      idle(1'b1, 10);
      chk($sformatf("tgl_press%0d", p), toggle, (p % 2 == 0) ? 1 : 0);
      idle(1'b0, 10);
      chk($sformatf("tgl_release%0d", p), toggle, (p % 2 == 0) ? 1 : 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Pulse exclusivity and single-cycle width, sampled mid-cycle
  logic prev_rise = 1'b0, prev_fall = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (rise && fall) chk("rise_fall_overlap", 1, 0);
      if (rise && prev_rise) chk("rise_double", 1, 0);
      if (fall && prev_fall) chk("fall_double", 1, 0);
    end
    prev_rise = rise;
    prev_fall = fall;
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Input-conditioning stage that sits directly upstream of the d_flip_flop register stage.
- Takes a raw asynchronous level, such as a push-button or external strobe, and synchronizes it into clk.
- Filters glitches shorter than a programmable stable window.
- Emits a clean level plus single-cycle rise/fall pulses; the clean level drives the downstream flop's d input.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- STABLE_CYCLES, 4, consecutive synchronized samples required to accept a new level; legal range >= 2.
- CNT_W, $clog2(STABLE_CYCLES+1), localparam, width of the stability counter; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  1  raw asynchronous input level.
- level  output  1  debounced, synchronized level.
- rise  output  1  one-cycle pulse when level goes 0->1.
- fall  output  1  one-cycle pulse when level goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset values:
  - Interface: one clock (clk); reset is asynchronous and active-high (reset).
  - While reset is high, all synchronizer flops = 0, FSM = S_LOW, cnt = 0.
  - While reset is high, level = 0, rise = 0, fall = 0, busy = 0.
- Synchronizer: a SYNC_STAGES-deep shift chain samples din; its last stage is sync. The FSM sees only sync, never din.
- FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK. All outputs are registered.
- S_LOW:
  - sync = 1 -> S_RISE_CHK, cnt <= 1.
  - Otherwise stay.
- S_RISE_CHK:
  - sync = 0 -> S_LOW, cnt <= 0. This is a glitch; no pulse is emitted.
  - sync = 1 and cnt == STABLE_CYCLES-1 -> S_HIGH, level <= 1, rise <= 1 for exactly one cycle, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- S_HIGH:
  - sync = 0 -> S_FALL_CHK, cnt <= 1.
- S_FALL_CHK: mirror of S_RISE_CHK.
  - sync = 1 -> back to S_HIGH, no pulse.
  - sync = 0 and cnt == STABLE_CYCLES-1 -> S_LOW, level <= 0, fall <= 1 for one cycle.
- busy = 1 exactly in S_RISE_CHK and S_FALL_CHK.
- Latency:
  - Edge 1 is the first rising edge that samples a din change.
  - With din held stable, level/rise/fall update on edge SYNC_STAGES+STABLE_CYCLES.
  - With defaults that is edge 6, i.e. 60 ns at 10 ns period.
- Glitch rule: a synchronized pulse of fewer than STABLE_CYCLES cycles never changes level and produces no pulse.
- Pulse exclusivity: rise and fall are never high in the same cycle. Each is never high two consecutive cycles.
- Counter: cnt never exceeds STABLE_CYCLES-1. There is no wrap-around.
- Reset mid-qualification: the FSM returns to S_LOW and any pending transition is discarded. After release, a din held high yields rise after the full latency again.
- din toggling every cycle: the FSM oscillates between S_LOW and S_RISE_CHK; level stays 0 indefinitely.

Optional Feature:
- Macro: DEBOUNCE_TOGGLE_EN.
- Defined:
  - Adds output port toggle (1 bit, reset 0), which inverts on every rise pulse, in the same cycle rise is registered.
  - fall has no effect on toggle.
  - Used to make a push-button an on/off switch.
- Undefined: port toggle and its flop are absent; all other behaviour is identical.

Decomposition:
- Shared package debounce_pkg:
  - FSM state encoding typedef (2-bit enum: S_LOW=0, S_RISE_CHK=1, S_HIGH=2, S_FALL_CHK=3).
  - Default constants DEF_SYNC_STAGES=2 and DEF_STABLE_CYCLES=4.
- One natural sub-module: sync_chain.
  - Parameterized SYNC_STAGES-deep flop chain with async active-high reset.
  - Instantiated once for din.
  - Reusable for other asynchronous inputs.

Test Plan:
- Reset, clk period 10 ns:
  - Stimulus: assert reset with din = 1, release reset at 20 ns.
  - Response: level = 0, rise = 0, busy = 0 while reset is high; rise pulses on edge 6 after release; level = 1 thereafter.
- Clean press/release:
  - Stimulus: din 0->1, hold 100 ns, then 1->0.
  - Response: rise is high for exactly one cycle 60 ns after the first sampling edge, and level = 1. fall is one cycle 60 ns after the release is sampled, and level = 0.
- Glitch rejection:
  - Stimulus: din high for 30 ns (3 sampled cycles), then low.
  - Response: busy asserts; level stays 0; rise and fall are never asserted.
- Bounce:
  - Stimulus: din toggles every 10 ns for 80 ns, then holds 1.
  - Response: no pulse during the bounce; exactly one rise, 60 ns after the hold begins.
- Reset mid-qualification:
  - Stimulus: din = 1; assert reset asynchronously during S_RISE_CHK (cnt = 2), between clock edges.
  - Response: busy and cnt clear immediately; no rise before reset releases; a full 60 ns latency applies after release.
- DEBOUNCE_TOGGLE_EN build:
  - Stimulus: three clean presses.
  - Response: toggle = 1, 0, 1 after each rise respectively; toggle is unchanged by fall.
